dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to rsp_valid_o (legal 1..15).
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk_i  in  1  clock, rising edge.
REQ-005 The block SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid_i  in  1  request valid.
REQ-007 The block SHALL have port req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-008 The block SHALL have port req_we_i  in  1  1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr_i  in  12  byte address.
REQ-010 The block SHALL have port req_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 The block SHALL have port req_unsigned_i  in  1  load zero-extend (funct3[2]).
REQ-012 The block SHALL have port req_wdata_i  in  32  store data, right-aligned.
REQ-013 The block SHALL have port rsp_valid_o  out  1  response valid.
REQ-014 The block SHALL have port rsp_ready_i  in  1  requester accepts response.
REQ-015 The block SHALL have port rsp_rdata_o  out  32  load result, extended.
REQ-016 The block SHALL have port rsp_err_o  out  1  access error.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 In IDLE, a request SHALL be accepted on req_valid_i&req_ready_o: latch we, addr, size, unsigned and wdata; go to WAIT, or straight to RESP when LATENCY=1.
REQ-019 In WAIT, a down-counter loaded with LATENCY-1 SHALL decrement each cycle; at 1 it SHALL go to RESP, so that rsp_valid_o rises exactly LATENCY cycles after the accept edge.
REQ-020 Load data SHALL be read and extended, and a store SHALL be committed, on the cycle entering RESP; storage is single-port, using word index addr[11:2] modulo DEPTH_WORDS.
REQ-021 Loads SHALL select the byte/half by addr[1:0], then sign-extend, or zero-extend when unsigned; a word load SHALL be passed unchanged.
REQ-022 Stores SHALL write only the addressed byte lanes, preserving the other lanes.
REQ-023 For a store response, rsp_rdata_o SHALL be 0.
REQ-024 RESP SHALL hold rsp_valid_o and all response fields stable until rsp_ready_i=1, then go to IDLE; no new request is accepted in that cycle.
REQ-025 Reserved size 11 SHALL behave as a word access.
REQ-026 Response fields SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-027 Asserting rst_ni low SHALL immediately force IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0 and counter=0.
REQ-028 Reset mid-transaction SHALL drop the request; a store not yet committed SHALL never be written.
REQ-029 Storage contents SHALL NOT be reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_CHECK_EN defined: a half access with addr[0]=1, a word access with addr[1:0]!=0, or size 11 SHALL produce rsp_err_o=1 and rsp_rdata_o=0, with no store commit and unchanged latency.
REQ-031 Macro DMEM_MISALIGN_CHECK_EN undefined: rsp_err_o SHALL be tied 0, and low address bits below access alignment SHALL be ignored (forced to 0).

Structure
REQ-032 Package dmem_pkg SHALL hold the size encodings, the FSM state enum and the default LATENCY/DEPTH_WORDS constants.
REQ-033 Sub-module dmem_lane_align (combinational) SHALL perform load extract/extend and store lane-merge, shared by read and write paths.

Verification
REQ-034 Scenario: reset, store word 0xDEADBEEF @0x010, load word @0x010 -> rsp_rdata_o=0xDEADBEEF, rsp_valid_o 2 cycles after each accept.
REQ-035 Scenario: store byte 0x80 @0x013 over 0x11223344, signed byte load @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080; word load -> 0x80223344.
REQ-036 Scenario: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0 throughout; accept next request only after handshake + 1 cycle.
REQ-037 Scenario: store accepted, rst_ni low during WAIT -> outputs at reset values immediately; a later load of that word returns the prior contents.
REQ-038 Scenario: half load @0x021 -> with DMEM_MISALIGN_CHECK_EN, rsp_err_o=1 and rdata=0; without it, returns the half at 0x020, err=0.
REQ-039 Scenario: LATENCY=1 build, back-to-back loads with rsp_ready_i=1 -> one response every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory slice.
package dmem_pkg;

  localparam int unsigned DEFAULT_LATENCY     = 2;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned ADDR_W              = 12;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned CNT_W               = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request payload as latched at accept time
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    size_e             size;
    logic              uns;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // True when the low address bits do not match the access alignment (reserved size always errs)
  function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte offset with the bits below access alignment forced to zero
  function automatic logic [1:0] align_offset(input size_e size, input logic [1:0] off);
    logic [1:0] a;
    case (size)
      SZ_BYTE: a = off;
      SZ_HALF: a = {off[1], 1'b0};
      default: a = 2'b00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store requester and dmem_responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering shared by the load and store paths: extract/extend on read, lane merge on write.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              uns,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] store_word_c
);

  logic [1:0]        off_a;
  logic [4:0]        sh;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  // Load extract/extend and store merge from the aligned lane offset
  always_comb begin
    off_a   = align_offset(size, offset);
    sh      = {off_a, 3'b000};
    shifted = mem_word >> sh;
    load_data_c = mem_word;
    mask        = '1;
    case (size)
      SZ_BYTE: begin
        load_data_c = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        mask        = 32'h0000_00FF << sh;
      end
      SZ_HALF: begin
        load_data_c = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        mask        = 32'h0000_FFFF << sh;
      end
      default: begin
        load_data_c = mem_word;
        mask        = '1;
      end
    endcase
    store_word_c = (mem_word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-port data memory responder with fixed request-to-response latency.
// Optional: define DMEM_MISALIGN_CHECK_EN to flag misaligned/reserved-size accesses via rsp_err_o.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY     = DEFAULT_LATENCY,
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input logic             clk_i,
  input logic             rst_ni,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_in, op;
  logic              accept_c, enter_resp_c, op_err_c;
  logic [IDX_W-1:0]  word_idx_c;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [DATA_W-1:0] mem_word_c, load_data_c, store_word_c;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept_c = (state_q == ST_IDLE) && bus.req_valid_i;

  // Live request when the access coincides with acceptance (LATENCY=1), latched one otherwise
  always_comb begin
    req_in.we    = bus.req_we_i;
    req_in.addr  = bus.req_addr_i;
    req_in.size  = size_e'(bus.req_size_i);
    req_in.uns   = bus.req_unsigned_i;
    req_in.wdata = bus.req_wdata_i;
    op = (state_q == ST_IDLE) ? req_in : req_q;
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign op_err_c = is_misaligned(op.size, op.addr[1:0]);
`else
  assign op_err_c = 1'b0;
`endif

  assign word_idx_c = IDX_W'(32'(op.addr[ADDR_W-1:2]) % DEPTH_WORDS);
  assign mem_word_c = mem[word_idx_c];

  dmem_lane_align u_align (
    .offset       (op.addr[1:0]),
    .size         (op.size),
    .uns          (op.uns),
    .mem_word     (mem_word_c),
    .wdata        (op.wdata),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Next-state and latency counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          if (LATENCY <= 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request payload on accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q <= req_in;
    end
  end

  // Storage: store commits on RESP entry; contents survive reset
  always_ff @(posedge clk_i) begin
    if (enter_resp_c && op.we && !op_err_c) begin
      mem[word_idx_c] <= store_word_c;
    end
  end

  // Response fields: loaded on RESP entry, cleared on the handshake so they read 0 when invalid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp_c) begin
      err_q   <= op_err_c;
      rdata_q <= (op.we || op_err_c) ? '0 : load_data_c;
    end else if ((state_q == ST_RESP) && bus.rsp_ready_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (LATENCY=2 instance plus a LATENCY=1 instance).
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus ();
  dmem_responder_if bus1 ();

  dmem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) dut (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus)
  );

  dmem_responder #(.LATENCY(1), .DEPTH_WORDS(64)) dut1 (
    .clk_i (clk), .rst_ni(rst_n), .bus(bus1)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [11:0] a, input logic [1:0] s,
                              input logic u, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = v.we;
    bus.req_addr_i     = v.addr;
    bus.req_size_i     = v.size;
    bus.req_unsigned_i = v.uns;
    bus.req_wdata_i    = v.wdata;
  endtask

  // One full transaction on the LATENCY=2 instance with immediate response acceptance
  task automatic run_vec(input string tag, input vec_t v);
    int n;
    @(negedge clk);
    drive_req(v);
    bus.rsp_ready_i = 1'b1;
    n = 0;
    while (!bus.req_ready_o && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    n = 1;
    while (!bus.rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, 2);
    check({tag, " rdata"}, bus.rsp_rdata_o, v.exp_rdata);
    check({tag, " err"}, bus.rsp_err_o, v.exp_err);
    @(posedge clk);
    #1;
    check({tag, " valid after handshake"}, bus.rsp_valid_o, 1'b0);
    check({tag, " rdata after handshake"}, bus.rsp_rdata_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prior;
    vec_t        v;
    int          n;

    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_addr_i = '0; bus.req_size_i = '0;
    bus.req_unsigned_i = 0; bus.req_wdata_i = '0; bus.rsp_ready_i = 0;
    bus1.req_valid_i = 0; bus1.req_we_i = 0; bus1.req_addr_i = '0; bus1.req_size_i = '0;
    bus1.req_unsigned_i = 0; bus1.req_wdata_i = '0; bus1.rsp_ready_i = 0;

    // ---- vector table: we, addr, size, unsigned, wdata, expected rdata, expected err
    add(1, 12'h010, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0);
    add(0, 12'h010, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0);
    add(1, 12'h010, 2'b10, 0, 32'h11223344, 32'h0, 0);
    add(1, 12'h013, 2'b00, 0, 32'hABCDEF80, 32'h0, 0);
    add(0, 12'h013, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0);
    add(0, 12'h013, 2'b00, 1, 32'h0, 32'h00000080, 0);
    add(0, 12'h010, 2'b10, 0, 32'h0, 32'h80223344, 0);
    add(0, 12'h012, 2'b01, 0, 32'h0, 32'hFFFF8022, 0);
    add(0, 12'h010, 2'b01, 1, 32'h0, 32'h00003344, 0);
    add(0, 12'h011, 2'b00, 0, 32'h0, 32'h00000033, 0);
    add(1, 12'h014, 2'b10, 0, 32'hCAFEF00D, 32'h0, 0);
    add(1, 12'h016, 2'b01, 0, 32'hABCD1234, 32'h0, 0);
    add(0, 12'h014, 2'b10, 0, 32'h0, 32'h1234F00D, 0);
    add(0, 12'h016, 2'b00, 1, 32'h0, 32'h00000034, 0);
    add(1, 12'h020, 2'b10, 0, 32'hA5B6C7D8, 32'h0, 0);
    add(0, 12'h021, 2'b01, 0, 32'h0, CHK ? 32'h0 : 32'hFFFFC7D8, CHK);
    add(0, 12'h021, 2'b01, 1, 32'h0, CHK ? 32'h0 : 32'h0000C7D8, CHK);
    add(0, 12'h012, 2'b10, 0, 32'h0, CHK ? 32'h0 : 32'h80223344, CHK);
    add(0, 12'h010, 2'b11, 0, 32'h0, CHK ? 32'h0 : 32'h80223344, CHK);
    add(1, 12'h011, 2'b10, 0, 32'hFFFFFFFF, 32'h0, CHK);
    add(0, 12'h010, 2'b10, 0, 32'h0, CHK ? 32'h80223344 : 32'hFFFFFFFF, 0);
    add(1, 12'h015, 2'b00, 0, 32'h00000077, 32'h0, 0);
    add(0, 12'h014, 2'b01, 0, 32'h0, 32'h0000770D, 0);
    add(0, 12'h017, 2'b00, 0, 32'h0, 32'h00000012, 0);
    add(1, 12'h023, 2'b01, 0, 32'h0000BEEF, 32'h0, CHK);
    add(0, 12'h020, 2'b10, 0, 32'h0, CHK ? 32'hA5B6C7D8 : 32'hBEEFC7D8, 0);

    // ---- reset values while reset is asserted
    rst_n = 1'b0;
    #1;
    check("reset req_ready", bus.req_ready_o, 1'b1);
    check("reset rsp_valid", bus.rsp_valid_o, 1'b0);
    check("reset rsp_rdata", bus.rsp_rdata_o, 32'h0);
    check("reset rsp_err", bus.rsp_err_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    prior = CHK ? 32'h80223344 : 32'hFFFFFFFF;

    // ---- backpressure: response held 5 cycles while a new request waits
    @(negedge clk);
    v.we = 0; v.addr = 12'h010; v.size = 2'b10; v.uns = 0; v.wdata = 32'h0;
    drive_req(v);
    bus.rsp_ready_i = 1'b0;
    @(posedge clk);
    #1;
    v.addr = 12'h013; v.size = 2'b00; v.uns = 1;
    drive_req(v);
    n = 1;
    while (!bus.rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    check("hold latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d valid", i), bus.rsp_valid_o, 1'b1);
      check($sformatf("hold%0d rdata", i), bus.rsp_rdata_o, prior);
      check($sformatf("hold%0d req_ready", i), bus.req_ready_o, 1'b0);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("hold handshake valid", bus.rsp_valid_o, 1'b0);
    check("hold handshake req_ready", bus.req_ready_o, 1'b1);
    @(posedge clk);
    #1;
    check("hold next accepted", bus.req_ready_o, 1'b0);
    bus.req_valid_i = 1'b0;
    n = 1;
    while (!bus.rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
    check("hold next latency", n, 2);
    check("hold next rdata", bus.rsp_rdata_o, CHK ? 32'h00000080 : 32'h000000FF);
    @(posedge clk);
    #1;

    // ---- reset during WAIT drops an accepted store
    @(negedge clk);
    v.we = 1; v.addr = 12'h010; v.size = 2'b10; v.uns = 0; v.wdata = 32'h55555555;
    drive_req(v);
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    check("midrst in wait", bus.req_ready_o, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst req_ready", bus.req_ready_o, 1'b1);
    check("midrst rsp_valid", bus.rsp_valid_o, 1'b0);
    check("midrst rsp_rdata", bus.rsp_rdata_o, 32'h0);
    check("midrst rsp_err", bus.rsp_err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    v.we = 0; v.wdata = 32'h0; v.exp_rdata = prior; v.exp_err = 0;
    run_vec("midrst reload", v);

    // ---- LATENCY=1: store then back-to-back loads, one response every 2 cycles
    @(negedge clk);
    bus1.req_valid_i = 1'b1; bus1.req_we_i = 1'b1; bus1.req_addr_i = 12'h104;
    bus1.req_size_i = 2'b10; bus1.req_unsigned_i = 1'b0; bus1.req_wdata_i = 32'h0BADF00D;
    bus1.rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("lat1 store valid", bus1.rsp_valid_o, 1'b1);
    check("lat1 store rdata", bus1.rsp_rdata_o, 32'h0);
    bus1.req_we_i = 1'b0;
    bus1.req_addr_i = 12'h004;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat1 cyc%0d valid", i), bus1.rsp_valid_o, (i % 2 == 1) ? 1'b1 : 1'b0);
      check($sformatf("lat1 cyc%0d req_ready", i), bus1.req_ready_o, (i % 2 == 1) ? 1'b0 : 1'b1);
      if (i % 2 == 1) check($sformatf("lat1 cyc%0d rdata", i), bus1.rsp_rdata_o, 32'h0BADF00D);
    end
    bus1.req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("lat1 drained", bus1.rsp_valid_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
